pipeline_stall_ctrl: RTL
========================

Name: pipeline_stall_ctrl

Overview:
Parametrised pipeline hazard controller. It replaces the per-stage hand-written stall blocks with one unit that owns a valid bit for every stage. It drives the per-stage load enables, inserts bubbles, squashes younger stages on a branch redirect with a load/ack handshake, and enforces a programmable fetch-refill penalty. It also keeps saturating stall and flush performance counters. Stage 0 is fetch and stage NUM_STAGES-1 is writeback.

Parameters:
NUM_STAGES, 5, number of pipeline stages (minimum 2)
SW, 3, width of stage index, must satisfy 2**SW >= NUM_STAGES
PENALTY, 2, fetch bubbles forced after an accepted redirect (0 allowed)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
fetch_valid  in  1  fetch stage has an instruction to enter stage 0
stall_req  in  NUM_STAGES  per-stage stall request; bit i means stage i cannot advance (dependency, memory wait, ...)
redirect  in  1  branch/jump resolved taken; held by requester until redirect_ack
redirect_stage  in  SW  stage index issuing the redirect; valid only while redirect=1
redirect_ack  out  1  redirect accepted this cycle
load  out  NUM_STAGES  per-stage pipeline register load enable
valid  out  NUM_STAGES  registered per-stage valid bits
fetch_kill  out  1  refill penalty active; fetch result discarded
stall_cycles  out  CNT_W  cycles with any stage frozen, saturating
flush_count  out  CNT_W  accepted redirects, saturating

Behaviour:
- Reset (async, immediate): valid=0, penalty counter=0, stall_cycles=0, flush_count=0. While reset=1, load=0 and redirect_ack=0 regardless of inputs.
- Oldest stall: k = highest index i with stall_req[i]=1 (combinational). Stages 0..k are frozen: load[i]=0 and valid[i] holds.
- Bubble below the stall: if k < NUM_STAGES-1, stage k+1 loads with valid[k+1]<=0 at the next edge. Stages above k+1 advance normally.
- No stall: all load=1. Then valid[i]<=valid[i-1] for i>=1, and valid[0]<=fetch_valid & ~fetch_kill.
- A stall request on an invalid stage still freezes that stage. The requester gates its own request.
- Redirect acceptance: redirect_ack=1 (combinational) when redirect=1, redirect_stage<NUM_STAGES, and stage redirect_stage is not frozen. Otherwise ack=0 and the request stays pending.
- Out-of-range redirect_stage is never acked.
- On an accepted redirect with stage r:
  - At the next edge, valid[0..r-1]<=0 (the younger stages are squashed).
  - Stage r advances or bubbles per the stall rules.
  - Stages above r are unaffected.
  - If k+1 <= r-1, the squash overrides the advance.
- Penalty counter:
  - Loaded with PENALTY on an accepted redirect.
  - fetch_kill=1 while counter>0.
  - Decrements only on cycles where load[0]=1.
  - A redirect accepted while the counter is nonzero reloads it to PENALTY.
  - PENALTY=0: fetch_kill stays 0.
- Simultaneous events:
  - Redirect plus a stall at k>=r: no ack.
  - Redirect plus a stall at k<r: ack, and the squash wins on the overlapping stages.
  - fetch_valid during fetch_kill is dropped.
- Counters:
  - stall_cycles increments when any stall_req bit is 1.
  - flush_count increments on each redirect_ack.
  - Both saturate at 2**CNT_W-1 and do not wrap.
- Reset asserted mid-operation clears all state within the same cycle. Pending requests are not remembered.
- Latency: load, redirect_ack and fetch_kill are combinational from the current state and inputs. valid reflects decisions one cycle later.

Test Plan:
1. Reset, then fetch_valid=1 for 6 cycles with no stalls -> valid walks 00001, 00011, … 11111; stall_cycles=0.
2. Pipe full, stall_req[3]=1 for 3 cycles -> load=10000, valid[4]=0 from the next edge, valid[0..3] held; stall_cycles=3; releasing the stall resumes flow.
3. Pipe full, redirect=1 with redirect_stage=2, no stall -> ack same cycle; next cycle valid[1:0]=00; fetch_kill=1 for exactly 2 cycles; flush_count=1.
4. stall_req[3]=1 with redirect at stage 2 held for 2 cycles -> ack=0 while the stall persists. After release: ack in the release cycle, squash on the next edge.
5. stall_req[1]=1 with redirect at stage 3 -> ack=1; valid[2:0]<=0 (the squash overrides the bubble at stage 2); stage 1 not held.
6. CNT_W=4, hold stall_req[0] for 20 cycles -> stall_cycles stops at 15. Assert reset mid-stall -> valid and counters are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake/bus bundle between the hazard controller and the pipeline stages.
// Master is the pipeline side (requests); slave is pipeline_stall_ctrl.
// Widths follow the controller parameters; instantiate with matching values.
interface pipeline_stall_ctrl_if #(
    parameter int NUM_STAGES = 5,
    parameter int SW         = 3,
    parameter int CNT_W      = 16
);
    logic                  fetch_valid;
    logic [NUM_STAGES-1:0] stall_req;
    logic                  redirect;
    logic [SW-1:0]         redirect_stage;
    logic                  redirect_ack;
    logic [NUM_STAGES-1:0] load;
    logic [NUM_STAGES-1:0] valid;
    logic                  fetch_kill;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output fetch_valid, stall_req, redirect, redirect_stage,
        input  redirect_ack, load, valid, fetch_kill, stall_cycles, flush_count
    );

    modport slave (
        input  fetch_valid, stall_req, redirect, redirect_stage,
        output redirect_ack, load, valid, fetch_kill, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline hazard controller: per-stage valid bits, load enables, bubbles, redirect squash, refill penalty.
// Latency: load/redirect_ack/fetch_kill combinational; valid updates one edge after the decision.
// Backpressure: stage k (oldest stall) freezes stages 0..k; redirects wait (no ack) while their stage is frozen.
module pipeline_stall_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int SW         = 3,
    parameter int PENALTY    = 2,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_stall_ctrl_if.slave   ctl
);
    localparam int PW = (PENALTY > 0) ? $clog2(PENALTY + 1) : 1;

    logic [NUM_STAGES-1:0] valid_q, valid_d;
    logic [PW-1:0]         pen_q, pen_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

    logic [NUM_STAGES-1:0] frozen;
    logic [NUM_STAGES-1:0] load_w;
    logic                  older_stall;
    logic [SW-1:0]         rstage;
    logic                  rstage_hit;
    logic                  rstage_frozen;
    logic                  ack_w;
    logic                  kill_w;

    assign rstage = ctl.redirect_stage;
    assign kill_w = (pen_q != '0);

    // Freeze mask: a stage is frozen when it or any older stage requests a stall.
    always_comb begin
        frozen      = '0;
        older_stall = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            older_stall = older_stall | ctl.stall_req[i];
            frozen[i]   = older_stall;
        end
    end

    // Redirect acceptance: in-range stage that is not frozen; never during reset.
    always_comb begin
        rstage_hit    = 1'b0;
        rstage_frozen = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (int'(rstage) == i) begin
                rstage_hit    = 1'b1;
                rstage_frozen = frozen[i];
            end
        end
        ack_w  = ctl.redirect & rstage_hit & ~rstage_frozen & ~reset;
        load_w = reset ? '0 : ~frozen;
    end

    // Next-state: hold frozen stages, bubble just above the oldest stall, advance the rest, then squash younger stages.
    always_comb begin
        valid_d = valid_q;
        valid_d[0] = frozen[0] ? valid_q[0] : (ctl.fetch_valid & ~kill_w);
        for (int i = 1; i < NUM_STAGES; i++) begin
            if (frozen[i])
                valid_d[i] = valid_q[i];
            else if (frozen[i-1])
                valid_d[i] = 1'b0;
            else
                valid_d[i] = valid_q[i-1];
        end
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (ack_w && (i < int'(rstage)))
                valid_d[i] = 1'b0;
        end
    end

    // Refill penalty and saturating performance counters.
    always_comb begin
        pen_d = pen_q;
        if (ack_w)
            pen_d = PW'(PENALTY);
        else if (kill_w && load_w[0])
            pen_d = pen_q - 1'b1;

        stall_cnt_d = stall_cnt_q;
        if ((|ctl.stall_req) && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;

        flush_cnt_d = flush_cnt_q;
        if (ack_w && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // State registers with immediate asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= '0;
            pen_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            pen_q       <= pen_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ctl.redirect_ack = ack_w;
    assign ctl.load         = load_w;
    assign ctl.valid        = valid_q;
    assign ctl.fetch_kill   = kill_w;
    assign ctl.stall_cycles = stall_cnt_q;
    assign ctl.flush_count  = flush_cnt_q;
endmodule
